// File: rtl/hazard_sequencer_pkg.sv
// hazard_pkg: shared sequencer state type and default stall limit.
package hazard_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} hazard_state_e;
    localparam int STALL_LIMIT_DEF = 1024;
endpackage

// File: rtl/hazard_sequencer_if.sv
// hazard_sequencer_if: hazard inputs and pipeline control outputs between the datapath (master) and the sequencer (slave).
interface hazard_sequencer_if #(parameter int ADDR_W = 32, parameter int REG_W = 5);
    logic              ic_miss, dc_miss, ex_mispredict, ex_is_load, dec_uses_rs, dec_uses_rt;
    logic [ADDR_W-1:0] ex_recovery_target, redirect_target;
    logic [REG_W-1:0]  ex_rw_addr, dec_rs_addr, dec_rt_addr;
    logic              pc_stall, pc_redirect, stall_timeout;
    logic              i2d_stall, i2d_flush, d2e_stall, d2e_flush, e2m_stall, e2m_flush, m2w_stall, m2w_flush;
    logic [31:0]       perf_dc_cyc, perf_ic_cyc, perf_lu_bub, perf_mispred;
    modport master (
        output ic_miss, dc_miss, ex_mispredict, ex_recovery_target, ex_is_load, ex_rw_addr,
               dec_uses_rs, dec_uses_rt, dec_rs_addr, dec_rt_addr,
        input  pc_stall, pc_redirect, redirect_target, stall_timeout,
               i2d_stall, i2d_flush, d2e_stall, d2e_flush, e2m_stall, e2m_flush, m2w_stall, m2w_flush,
               perf_dc_cyc, perf_ic_cyc, perf_lu_bub, perf_mispred
    );
    modport slave (
        input  ic_miss, dc_miss, ex_mispredict, ex_recovery_target, ex_is_load, ex_rw_addr,
               dec_uses_rs, dec_uses_rt, dec_rs_addr, dec_rt_addr,
        output pc_stall, pc_redirect, redirect_target, stall_timeout,
               i2d_stall, i2d_flush, d2e_stall, d2e_flush, e2m_stall, e2m_flush, m2w_stall, m2w_flush,
               perf_dc_cyc, perf_ic_cyc, perf_lu_bub, perf_mispred
    );
endinterface

// File: rtl/hazard_sequencer_load_use_detect.sv
// hazard_load_use_detect: flags a decode source that depends on a load still in EX.
module hazard_load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             i_ex_is_load,
    input  logic [REG_W-1:0] i_ex_rw_addr,
    input  logic             i_dec_uses_rs,
    input  logic             i_dec_uses_rt,
    input  logic [REG_W-1:0] i_dec_rs_addr,
    input  logic [REG_W-1:0] i_dec_rt_addr,
    output logic             o_lu_hazard
);
    logic w_rs_hit, w_rt_hit;
    assign w_rs_hit    = i_dec_uses_rs && i_dec_rs_addr == i_ex_rw_addr;
    assign w_rt_hit    = i_dec_uses_rt && i_dec_rt_addr == i_ex_rw_addr;
    assign o_lu_hazard = i_ex_is_load && i_ex_rw_addr != '0 && (w_rs_hit || w_rt_hit);
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline stall/flush/redirect arbiter with deferred redirect and stall timeout.
// Define HAZARD_PERF_CNT_EN to build the performance counters; otherwise the perf ports read 0.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int REG_W       = 5,
    parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
    input logic clk,
    input logic rst_n,
    hazard_sequencer_if.slave hz
);
    localparam int CNT_W = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(STALL_LIMIT - 1);

    hazard_state_e     r_state;
    logic              r_pend_v;
    logic [ADDR_W-1:0] r_pend_t;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic w_lu, w_halt, w_run, w_dc, w_rel, w_rel_rd, w_open, w_live, w_lu_bub, w_ic, w_rd, w_stall_ev;

    hazard_load_use_detect #(.REG_W(REG_W)) u_lu (
        .i_ex_is_load (hz.ex_is_load),
        .i_ex_rw_addr (hz.ex_rw_addr),
        .i_dec_uses_rs(hz.dec_uses_rs),
        .i_dec_uses_rt(hz.dec_uses_rt),
        .i_dec_rs_addr(hz.dec_rs_addr),
        .i_dec_rt_addr(hz.dec_rt_addr),
        .o_lu_hazard  (w_lu)
    );

    // Hazard classes are mutually exclusive, resolved in priority order; all quiet while in reset.
    assign w_halt     = r_state == HALT;
    assign w_run      = rst_n && !w_halt;
    assign w_dc       = w_run && hz.dc_miss;
    assign w_rel      = w_run && !hz.dc_miss && r_state == MEM_WAIT;
    assign w_rel_rd   = w_rel && r_pend_v;
    assign w_open     = w_run && !hz.dc_miss && r_state != MEM_WAIT;
    assign w_live     = w_open && hz.ex_mispredict;
    assign w_lu_bub   = w_open && !hz.ex_mispredict && w_lu;
    assign w_ic       = w_open && !hz.ex_mispredict && !w_lu && hz.ic_miss;
    assign w_rd       = w_live || w_rel_rd;
    assign w_stall_ev = w_dc || w_ic;

    assign hz.pc_stall        = w_halt || w_dc || w_lu_bub || w_ic;
    assign hz.i2d_stall       = w_halt || w_dc || w_lu_bub;
    assign hz.d2e_stall       = w_halt || w_dc;
    assign hz.e2m_stall       = w_halt || w_dc;
    assign hz.m2w_stall       = w_halt;
    assign hz.i2d_flush       = w_rd || w_ic;
    assign hz.d2e_flush       = w_rd || w_lu_bub;
    assign hz.e2m_flush       = 1'b0;
    assign hz.m2w_flush       = w_dc;
    assign hz.pc_redirect     = w_rd;
    assign hz.redirect_target = !w_rd ? '0 : w_rel_rd ? r_pend_t : hz.ex_recovery_target;
    assign hz.stall_timeout   = w_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_pend_v    <= 1'b0;
            r_pend_t    <= '0;
            r_stall_cnt <= '0;
        end else if (w_run) begin
            r_stall_cnt <= !w_stall_ev ? '0 : &r_stall_cnt ? r_stall_cnt : r_stall_cnt + CNT_W'(1);
            r_state     <= (w_stall_ev && r_stall_cnt == LIM_M1) ? HALT : w_dc ? MEM_WAIT : RUN;
            // Only the first mispredict seen during a miss is kept; younger ones are on the wrong path.
            if (w_dc && hz.ex_mispredict && !r_pend_v) begin
                r_pend_v <= 1'b1;
                r_pend_t <= hz.ex_recovery_target;
            end else if (w_rel) begin
                r_pend_v <= 1'b0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_dc, r_perf_ic, r_perf_lu, r_perf_mp;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_perf_dc, r_perf_ic, r_perf_lu, r_perf_mp} <= '0;
        end else if (w_run) begin
            r_perf_dc <= r_perf_dc + 32'(w_dc);
            r_perf_ic <= r_perf_ic + 32'(w_ic);
            r_perf_lu <= r_perf_lu + 32'(w_lu_bub);
            r_perf_mp <= r_perf_mp + 32'(w_rd);
        end
    end
    assign hz.perf_dc_cyc  = r_perf_dc;
    assign hz.perf_ic_cyc  = r_perf_ic;
    assign hz.perf_lu_bub  = r_perf_lu;
    assign hz.perf_mispred = r_perf_mp;
`else
    assign hz.perf_dc_cyc  = '0;
    assign hz.perf_ic_cyc  = '0;
    assign hz.perf_lu_bub  = '0;
    assign hz.perf_mispred = '0;
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed and randomized checks of two sequencers (default and short stall limit) against a priority-table model.
module tb_hazard_sequencer;
    localparam int LIM_A = 1024;
    localparam int LIM_B = 4;
    localparam int PS = 10, PR = 9, IS = 8, IF = 7, DS = 6, DF = 5, ES = 4, EF = 3, MS = 2, MF = 1, TO = 0;

    typedef struct packed {
        logic [10:0]  ctrl;
        logic [31:0]  tgt;
        logic [127:0] perf;
    } obs_t;

    typedef struct packed {
        logic [1:0]  st;
        logic        pv;
        logic [31:0] pt;
        logic [31:0] cnt;
        logic [31:0] pdc, pic, plu, pmp;
    } m_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    m_t   ma = '0;
    m_t   mb = '0;
    obs_t oa, ob;

    hazard_sequencer_if #(.ADDR_W(32), .REG_W(5)) ifa();
    hazard_sequencer_if #(.ADDR_W(32), .REG_W(5)) ifb();

    hazard_sequencer #(.ADDR_W(32), .REG_W(5), .STALL_LIMIT(LIM_A)) dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa.slave));
    hazard_sequencer #(.ADDR_W(32), .REG_W(5), .STALL_LIMIT(LIM_B)) dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb.slave));

    always #5 clk = ~clk;

    always_comb begin
        ifb.ic_miss            = ifa.ic_miss;
        ifb.dc_miss            = ifa.dc_miss;
        ifb.ex_mispredict      = ifa.ex_mispredict;
        ifb.ex_recovery_target = ifa.ex_recovery_target;
        ifb.ex_is_load         = ifa.ex_is_load;
        ifb.ex_rw_addr         = ifa.ex_rw_addr;
        ifb.dec_uses_rs        = ifa.dec_uses_rs;
        ifb.dec_uses_rt        = ifa.dec_uses_rt;
        ifb.dec_rs_addr        = ifa.dec_rs_addr;
        ifb.dec_rt_addr        = ifa.dec_rt_addr;
    end

    assign oa = {ifa.pc_stall, ifa.pc_redirect, ifa.i2d_stall, ifa.i2d_flush, ifa.d2e_stall, ifa.d2e_flush,
                 ifa.e2m_stall, ifa.e2m_flush, ifa.m2w_stall, ifa.m2w_flush, ifa.stall_timeout, ifa.redirect_target,
                 ifa.perf_dc_cyc, ifa.perf_ic_cyc, ifa.perf_lu_bub, ifa.perf_mispred};
    assign ob = {ifb.pc_stall, ifb.pc_redirect, ifb.i2d_stall, ifb.i2d_flush, ifb.d2e_stall, ifb.d2e_flush,
                 ifb.e2m_stall, ifb.e2m_flush, ifb.m2w_stall, ifb.m2w_flush, ifb.stall_timeout, ifb.redirect_target,
                 ifb.perf_dc_cyc, ifb.perf_ic_cyc, ifb.perf_lu_bub, ifb.perf_mispred};

    task automatic chk(input string nm, input logic [170:0] act, input logic [170:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Model: pick the single winning hazard class, then read its control pattern from a table.
    function automatic void step(input m_t m, input int lim, output obs_t e, output m_t n);
        int  kind;
        logic lu, sev;
        n = m;
        e = '0;
        if (!rst_n) return;
`ifdef HAZARD_PERF_CNT_EN
        e.perf = {m.pdc, m.pic, m.plu, m.pmp};
`endif
        if (m.st == 2) begin
            e.ctrl = 11'b101_0101_0101;
            return;
        end
        lu = ifa.ex_is_load && ifa.ex_rw_addr != 0 &&
             ((ifa.dec_uses_rs && ifa.dec_rs_addr == ifa.ex_rw_addr) ||
              (ifa.dec_uses_rt && ifa.dec_rt_addr == ifa.ex_rw_addr));
        kind = ifa.dc_miss ? 1 : (m.st == 1) ? 2 : ifa.ex_mispredict ? 3 : lu ? 4 : ifa.ic_miss ? 5 : 0;
        case (kind)
            1: e.ctrl = 11'b101_0101_0010;
            2: if (m.pv) begin e.ctrl = 11'b010_1010_0000; e.tgt = m.pt; end
            3: begin e.ctrl = 11'b010_1010_0000; e.tgt = ifa.ex_recovery_target; end
            4: e.ctrl = 11'b101_0010_0000;
            5: e.ctrl = 11'b100_1000_0000;
            default: e.ctrl = '0;
        endcase
        sev = kind == 1 || kind == 5;
        n.cnt = !sev ? 0 : (m.cnt < lim) ? m.cnt + 1 : m.cnt;
        n.st  = (sev && m.cnt == lim - 1) ? 2 : (kind == 1) ? 1 : 0;
        if (kind == 1 && ifa.ex_mispredict && !m.pv) begin
            n.pv = 1'b1;
            n.pt = ifa.ex_recovery_target;
        end
        if (kind == 2) n.pv = 1'b0;
        n.pdc = m.pdc + 32'(kind == 1);
        n.pic = m.pic + 32'(kind == 5);
        n.plu = m.plu + 32'(kind == 4);
        n.pmp = m.pmp + 32'(e.ctrl[PR]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        obs_t e;
        m_t   n;
        if (!rst_n) begin
            ma = '0;
            mb = '0;
        end else begin
            step(ma, LIM_A, e, n);
            ma = n;
            step(mb, LIM_B, e, n);
            mb = n;
        end
    end

    always @(negedge clk) begin
        obs_t e;
        m_t   n;
        step(ma, LIM_A, e, n);
        chk("cycle_a", oa, e);
        step(mb, LIM_B, e, n);
        chk("cycle_b", ob, e);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        ifa.ic_miss = 0; ifa.dc_miss = 0; ifa.ex_mispredict = 0; ifa.ex_recovery_target = 0;
        ifa.ex_is_load = 0; ifa.ex_rw_addr = 0; ifa.dec_uses_rs = 0; ifa.dec_uses_rt = 0;
        ifa.dec_rs_addr = 0; ifa.dec_rt_addr = 0;
    endtask

    task automatic rst_pulse();
        cyc();
        idle();
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", oa, '0);
        chk("reset_b", ob, '0);
        rst_n = 1;

        cyc(); ifa.ex_is_load = 1; ifa.ex_rw_addr = 8; ifa.dec_uses_rs = 1; ifa.dec_rs_addr = 8;
        mid(); chk("lu_ctrl", {oa.ctrl[PS], oa.ctrl[IS], oa.ctrl[DF], oa.ctrl[DS], oa.ctrl[PR]}, 5'b11100);
        cyc(); ifa.ex_rw_addr = 0; ifa.dec_rs_addr = 0;
        mid(); chk("lu_r0", oa.ctrl, '0);

        cyc(); idle(); ifa.ex_mispredict = 1; ifa.ex_recovery_target = 32'h0040_0100; ifa.ic_miss = 1;
        mid(); chk("live_ctrl", {oa.ctrl[PR], oa.ctrl[IF], oa.ctrl[DF], oa.ctrl[PS]}, 4'b1110);
        chk("live_tgt", oa.tgt, 32'h0040_0100);

        for (int c = 0; c < 5; c++) begin
            cyc(); idle(); ifa.dc_miss = 1;
            if (c == 2) begin ifa.ex_mispredict = 1; ifa.ex_recovery_target = 32'h0040_0200; end
            if (c == 3) begin ifa.ex_mispredict = 1; ifa.ex_recovery_target = 32'h0040_0300; end
            mid(); chk("defer_hold", {oa.ctrl[ES], oa.ctrl[MF], oa.ctrl[PR]}, 3'b110);
        end
        cyc(); idle();
        mid(); chk("defer_rd", oa.ctrl[PR], 1'b1);
        chk("defer_tgt", oa.tgt, 32'h0040_0200);
        cyc();
        mid(); chk("defer_once", oa.ctrl[PR], 1'b0);

        rst_pulse();
        repeat (3) begin cyc(); idle(); ifa.dc_miss = 1; end
        cyc(); idle();
        cyc(); ifa.ex_is_load = 1; ifa.ex_rw_addr = 3; ifa.dec_uses_rt = 1; ifa.dec_rt_addr = 3;
        repeat (2) begin cyc(); idle(); ifa.ex_mispredict = 1; ifa.ex_recovery_target = 32'h1000; end
        cyc(); idle();
        mid();
`ifdef HAZARD_PERF_CNT_EN
        chk("perf", oa.perf, {32'd3, 32'd0, 32'd1, 32'd2});
`else
        chk("perf", oa.perf, '0);
`endif

        rst_pulse();
        for (int c = 0; c < 6; c++) begin
            cyc(); idle(); ifa.dc_miss = 1;
            mid();
            if (c == 3) chk("to_before", ob.ctrl[TO], 1'b0);
            if (c == 4) chk("to_halt", ob.ctrl, 11'b101_0101_0101);
        end
        cyc(); idle(); ifa.ex_mispredict = 1; ifa.ex_recovery_target = 32'h2000;
        mid(); chk("to_sticky", ob.ctrl, 11'b101_0101_0101);
        chk("to_tgt", ob.tgt, '0);
        rst_pulse();
        mid(); chk("to_cleared", ob.ctrl, '0);

        rst_pulse();
        cyc(); idle(); ifa.dc_miss = 1; ifa.ex_mispredict = 1; ifa.ex_recovery_target = 32'h0000_0500;
        cyc(); idle(); ifa.dc_miss = 1;
        cyc(); idle(); ifa.dc_miss = 1;
        #2 rst_n = 0;
        #1 chk("async_zero", oa, '0);
        rst_n = 1;
        cyc(); idle();
        mid(); chk("async_no_rd", oa.ctrl[PR], 1'b0);

        for (int i = 0; i < 3000; i++) begin
            cyc();
            ifa.dc_miss            = $urandom_range(0, 3) == 0;
            ifa.ex_mispredict      = $urandom_range(0, 6) == 0;
            ifa.ex_recovery_target = $urandom;
            ifa.ic_miss            = $urandom_range(0, 4) == 0;
            ifa.ex_is_load         = $urandom_range(0, 1) == 0;
            ifa.ex_rw_addr         = 5'($urandom_range(0, 3));
            ifa.dec_uses_rs        = $urandom_range(0, 1) == 0;
            ifa.dec_uses_rt        = $urandom_range(0, 1) == 0;
            ifa.dec_rs_addr        = 5'($urandom_range(0, 3));
            ifa.dec_rt_addr        = 5'($urandom_range(0, 3));
            if (i % 250 == 249) begin
                rst_n = 0;
                #2 rst_n = 1;
            end
        end
        cyc(); idle();
        mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
